pulse_measure_pio: RTL
======================

Name: pulse_measure_pio

Overview:
- Receive-side counterpart to pulse_generator_pio: measures an incoming pulse train and reports delay, width, gap and pulse count to HPS-visible PIO registers.
- Armed by a PIO level bit, edge-detected in the same way as the generator's start input.
- Used for loopback self-test of the generator and for characterising external pulse sources.

Parameters:
- SYNC_STAGES, 2, flop depth of the input synchronizer applied to both pulse_in and arm_pio (≥2).
- CNT_W, 32, width of all cycle counters and result registers.
- REP_W, 16, width of expected_count and pulse_count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- arm_pio  in  1  PIO level; a rising edge arms a new measurement.
- pulse_in  in  1  pulse under measurement; asynchronous to clk.
- expected_count  in  REP_W  number of complete pulses to measure; 0 = unlimited (ends only by timeout or re-arm).
- timeout_cycles  in  CNT_W  idle limit in cycles with no edge; 0 = no timeout.
- delay_meas  out  CNT_W  cycles from arm to first rising edge.
- width_meas  out  CNT_W  high time of the most recent pulse.
- gap_meas  out  CNT_W  low time between the two most recent pulses.
- pulse_count  out  REP_W  rising edges counted since arm.
- busy  out  1  measurement in progress.
- done  out  1  measurement finished; held until the next arm.
- timed_out  out  1  done was caused by timeout.
- measure_led  out  1  equals busy.

Behaviour:
- Reset: every output is 0; state is IDLE; synchronizer flops are 0.
- Input conditioning:
  - arm_pio and pulse_in each pass through a SYNC_STAGES-deep chain, so both paths have equal latency.
  - arm_s, pulse_s are the synchronized signals; *_d are one more registered copy.
  - arm_rise = arm_s & ~arm_s_d.
  - p_rise / p_fall are the rising / falling edges of pulse_s.
- Timing reference:
  - t0 = cycle arm_rise is asserted; t1 = cycle of a p_rise; t2 = cycle of a p_fall.
  - Synchronizer latency cancels out, so all results are in raw input cycles.
- States: IDLE, WAIT_FIRST, HIGH, LOW, DONE.
- arm_rise, from any state:
  - clears all results, done and timed_out; counter := 0; busy := 1.
  - Goes to WAIT_FIRST; goes to HIGH instead if p_rise or pulse_s=1 in the same cycle. In that case delay_meas = 0 and pulse_count = 1.
  - arm_pio falling has no effect.
- WAIT_FIRST:
  - Counter increments each cycle.
  - On p_rise: delay_meas := t1 - t0; pulse_count := 1; counter := 0; go to HIGH.
- HIGH:
  - Counter increments each cycle.
  - On p_fall: width_meas := t2 - t1.
  - If pulse_count == expected_count (expected_count ≠ 0): go to DONE.
  - Otherwise counter := 0 and go to LOW.
- LOW:
  - On p_rise: gap_meas := cycles low; pulse_count += 1 (saturating at all-ones); go to HIGH.
- Timeout:
  - In WAIT_FIRST, HIGH or LOW, when timeout_cycles ≠ 0 and the counter reaches timeout_cycles - 1 with no edge that cycle: go to DONE with timed_out := 1.
  - In HIGH, width_meas := partial count; pulse_count is unchanged.
  - In WAIT_FIRST, delay_meas := timeout_cycles.
- DONE: busy := 0, done := 1; all results held until the next arm_rise.
- Width and arithmetic:
  - All counters saturate at 2^CNT_W - 1 and never wrap.
  - expected_count is compared at full REP_W width.
- Input sampling: expected_count and timeout_cycles are sampled live; software must hold them stable while busy.
- Latency: results and done are valid in the cycle after the terminating edge is detected. Total latency is SYNC_STAGES+2 cycles from the raw input edge.
- Reset asserted mid-measurement: everything clears immediately (asynchronous), and there is no pending arm afterwards.

Decomposition:
- Shared package pulse_pkg holds:
  - the state enum: IDLE, WAIT_FIRST, HIGH, LOW, DONE;
  - CNT_W/REP_W defaults;
  - the CNT_MAX saturation constant.
- pulse_generator_pio is to import the same package.
- One sub-module, sync_edge_detect (parameter SYNC_STAGES):
  - single-bit synchronizer, registered copy, and rise/fall outputs;
  - instantiated twice, once for arm_pio and once for pulse_in.

Test Plan:
- Single pulse: arm, pulse_in high 3 cycles after arm for 2 cycles, expected_count=1.
  - Expect delay_meas=3, width_meas=2, pulse_count=1, done=1, timed_out=0, busy=0.
- Two reps: delay 2, width 1, low 2, expected_count=2.
  - Expect delay_meas=2, width_meas=1, gap_meas=2, pulse_count=2, done set 1 cycle after the second fall.
- Timeout with no pulse: timeout_cycles=50, no pulse.
  - Expect done=1 and timed_out=1 exactly 50 cycles after t0; pulse_count=0; delay_meas=50.
- Coincident arm and rise: pulse_in and arm_pio rise on the same edge, width 10, expected_count=1.
  - Expect delay_meas=0, width_meas=10.
- Re-arm mid-measurement: arm, 2 pulses of width 15 with expected_count=0, then toggle arm low/high, then one pulse of width 4 with timeout 20.
  - Expect results cleared at the re-arm; then pulse_count=1, width_meas=4, timed_out=1.
- Loopback plus reset: drive pulse_in from pulse_generator_pio (delay 20, width 15, reps 2), with arm_pio tied to the generator's start_pio.
  - Expect width_meas=15, gap_meas=20, pulse_count=2.
  - Then assert reset_n=0 mid-train: all outputs 0 at once, and they stay 0 until the next arm.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator / pulse measurement PIO pair:
// measurement state encoding, default widths and the saturation constant.
package pulse_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int REP_W_DEF = 16;

  // All-ones source for saturating counters; slice to the counter width.
  // Wide enough for any counter up to 64 bits.
  localparam logic [63:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    HIGH,
    LOW,
    DONE
  } meas_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Single-bit synchronizer for an asynchronous input, followed by one more
// register so rising and falling edges of the synchronized level can be
// flagged for exactly one clock.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync_d;

  // Shift the raw input through the synchronizer, then keep one delayed copy.
  // NOTE: non-blocking assignments make every flop sample pre-edge values, so
  // the chain shifts by exactly one stage per clock regardless of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain  <= '0;
      sync_d <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], din};
      sync_d <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_d;
  assign fall     = ~sync_out & sync_d;

endmodule

// File: rtl/pulse_measure_pio.sv
// Measures an incoming pulse train after a PIO arm edge: delay to the first
// rising edge, width of the latest pulse, gap before it, and pulse count.
// Both the arm and the pulse input go through identical synchronizers, so
// their latency cancels and all results are in raw input cycles.
module pulse_measure_pio
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int REP_W       = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm_pio,
  input  logic             pulse_in,
  input  logic [REP_W-1:0] expected_count,
  input  logic [CNT_W-1:0] timeout_cycles,
  output logic [CNT_W-1:0] delay_meas,
  output logic [CNT_W-1:0] width_meas,
  output logic [CNT_W-1:0] gap_meas,
  output logic [REP_W-1:0] pulse_count,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             measure_led
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_MAX[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_SAT = CNT_MAX[REP_W-1:0];
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  meas_state_t state, state_nxt;

  logic             arm_s, arm_rise_raw, arm_fall_unused, arm_rise;
  logic             pulse_s, p_rise, p_fall;
  logic [SYNC_STAGES:0] warm;
  logic             arm_ok;

  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] delay_nxt, width_nxt, gap_nxt;
  logic [REP_W-1:0] count_nxt, count_inc;
  logic             busy_nxt, done_nxt, tmo_nxt;
  logic             tmo_hit, count_hit;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_arm_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (arm_pio),
    .sync_out (arm_s),
    .rise     (arm_rise_raw),
    .fall     (arm_fall_unused)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (pulse_in),
    .sync_out (pulse_s),
    .rise     (p_rise),
    .fall     (p_fall)
  );

  // After reset the synchronizer holds zeros, so an arm level that stayed high
  // through reset would look like a fresh edge. Only accept arm edges once the
  // chain reflects the real input and the arm level has been seen low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm   <= '0;
      arm_ok <= 1'b0;
    end else begin
      warm   <= {warm[SYNC_STAGES-1:0], 1'b1};
      arm_ok <= arm_ok | (warm[SYNC_STAGES] & ~arm_s);
    end
  end

  assign arm_rise  = arm_rise_raw & arm_ok;

  // Counter value plus one is the elapsed cycle count since the reference edge.
  assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
  assign count_inc = (pulse_count == REP_SAT) ? pulse_count : pulse_count + REP_ONE;
  assign tmo_hit   = (timeout_cycles != '0) && (cnt == timeout_cycles - CNT_ONE);
  assign count_hit = (expected_count != '0) && (pulse_count == expected_count);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, counter and result updates.
  // NOTE: every variable gets its hold value first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    delay_nxt = delay_meas;
    width_nxt = width_meas;
    gap_nxt   = gap_meas;
    count_nxt = pulse_count;
    busy_nxt  = busy;
    done_nxt  = done;
    tmo_nxt   = timed_out;

    if (arm_rise) begin
      cnt_nxt   = '0;
      delay_nxt = '0;
      width_nxt = '0;
      gap_nxt   = '0;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      tmo_nxt   = 1'b0;
      if (pulse_s) begin
        state_nxt = HIGH;
        count_nxt = REP_ONE;
      end else begin
        state_nxt = WAIT_FIRST;
        count_nxt = '0;
      end
    end else begin
      unique case (state)
        WAIT_FIRST: begin
          cnt_nxt = cnt_inc;
          if (p_rise) begin
            delay_nxt = cnt_inc;
            count_nxt = REP_ONE;
            cnt_nxt   = '0;
            state_nxt = HIGH;
          end else if (tmo_hit) begin
            delay_nxt = timeout_cycles;
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            tmo_nxt   = 1'b1;
          end
        end
        HIGH: begin
          cnt_nxt = cnt_inc;
          if (p_fall) begin
            width_nxt = cnt_inc;
            if (count_hit) begin
              state_nxt = DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              cnt_nxt   = '0;
              state_nxt = LOW;
            end
          end else if (tmo_hit) begin
            width_nxt = cnt_inc;
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            tmo_nxt   = 1'b1;
          end
        end
        LOW: begin
          cnt_nxt = cnt_inc;
          if (p_rise) begin
            gap_nxt   = cnt_inc;
            count_nxt = count_inc;
            cnt_nxt   = '0;
            state_nxt = HIGH;
          end else if (tmo_hit) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            tmo_nxt   = 1'b1;
          end
        end
        default: ; // IDLE and DONE hold everything until the next arm
      endcase
    end
  end

  // Counter, results and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      delay_meas  <= '0;
      width_meas  <= '0;
      gap_meas    <= '0;
      pulse_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      delay_meas  <= delay_nxt;
      width_meas  <= width_nxt;
      gap_meas    <= gap_nxt;
      pulse_count <= count_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      timed_out   <= tmo_nxt;
    end
  end

  assign measure_led = busy;

endmodule
